alu_mul_seq: RTL and testbench

Iterative 32×32→64 shift-add multiplier sequencer that borrows the shared `alu` instead of instantiating its own adder. It sits beside the execute stage. It requests the ALU with a req/gnt handshake and issues one `ADD` per granted cycle, 32 in total. It captures the ALU carry-out and shifts a 64-bit product register internally. An optional two-step `SUB` correction stage produces signed products.

---
 rtl/alu_mul_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_mul_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
// ---------------------------------------------------------------------------
// alu_mul_seq -- iterative 32x32->64 shift-add multiplier that borrows the
// shared combinational ALU for every add/subtract instead of owning an adder.
//
// Each granted ITER cycle issues one ADD of hi + (lo[0] ? mcand : 0). The
// {carry, sum} pair is then shifted right one place across the hi:lo product
// register. Thirty-two grants complete the unsigned product.
//
// Optional feature macro: MUL_SIGNED_EN
//   When it is defined, the signed_in port exists. A signed product is built
//   from the unsigned one by up to two SUB corrections of the high word:
//     CORR_A: hi -= multiplier    (when multiplicand is negative)
//     CORR_B: hi -= multiplicand  (when multiplier is negative)
//   When it is undefined, only ADD/PASS are ever issued and the result is
//   always unsigned.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a multiply (ignored while busy)
//   multiplicand/multiplier operands, latched on an accepted start
//   signed_in               two's-complement operands (MUL_SIGNED_EN only)
//   busy, done              sequencer active / one-cycle result-valid pulse
//   product_hi/product_lo   64-bit result, held until the next start
//   alu_req/alu_gnt/alu_oe  ALU borrow handshake; oe = req & gnt
//   alu_op/alu_a/alu_b      operation and operands presented to the ALU
//   alu_carry_in            always 0
//   alu_out/alu_status      ALU result and {N,Z,C,V} flags, same cycle
// ---------------------------------------------------------------------------

package alu_pkg;
    typedef enum logic [3:0] {
        PASS = 4'd0,
        ADD  = 4'd1,
        SUB  = 4'd2
    } alu_op_e;
endpackage

module alu_mul_seq (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [31:0]         multiplicand,
    input  logic [31:0]         multiplier,
`ifdef MUL_SIGNED_EN
    input  logic                signed_in,
`endif
    output logic                busy,
    output logic                done,
    output logic [31:0]         product_lo,
    output logic [31:0]         product_hi,
    output logic                alu_req,
    input  logic                alu_gnt,
    output logic                alu_oe,
    output alu_pkg::alu_op_e    alu_op,
    output logic                alu_carry_in,
    output logic [31:0]         alu_a,
    output logic [31:0]         alu_b,
    input  logic [31:0]         alu_out,
    input  logic [3:0]          alu_status
);

    // state  | meaning
    // IDLE   | waiting for start, product held
    // ITER   | shift-add iterations, one per ALU grant
    // CORR_A | signed fix-up: hi -= original multiplier
    // CORR_B | signed fix-up: hi -= multiplicand
    // DONE   | one-cycle result-valid pulse
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ITER   = 3'd1,
`ifdef MUL_SIGNED_EN
        CORR_A = 3'd2,
        CORR_B = 3'd3,
`endif
        DONE   = 3'd4
    } state_e;

    state_e      state;
    logic [31:0] mcand;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  cnt;
`ifdef MUL_SIGNED_EN
    logic [31:0] orig_b;     // multiplier before lo is shifted away
    logic        sgn;
`endif

    // Only the carry flag participates in the algorithm.
    logic status_unused;
    assign status_unused = ^{alu_status[3:2], alu_status[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_req <= 1'b0;
            alu_op  <= alu_pkg::PASS;
`ifdef MUL_SIGNED_EN
            orig_b  <= '0;
            sgn     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand   <= multiplicand;
                        lo      <= multiplier;
                        hi      <= '0;
                        cnt     <= '0;
`ifdef MUL_SIGNED_EN
                        orig_b  <= multiplier;
                        sgn     <= signed_in;
`endif
                        state   <= ITER;
                        busy    <= 1'b1;
                        alu_req <= 1'b1;
                        alu_op  <= alu_pkg::ADD;
                    end
                end
                ITER: begin
                    if (alu_gnt) begin
                        // carry-out becomes hi[31]; sum LSB enters lo from the top
                        hi  <= {alu_status[1], alu_out[31:1]};
                        lo  <= {alu_out[0], lo[31:1]};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
`ifdef MUL_SIGNED_EN
                            if (sgn && mcand[31]) begin
                                state  <= CORR_A;
                                alu_op <= alu_pkg::SUB;
                            end else if (sgn && orig_b[31]) begin
                                state  <= CORR_B;
                                alu_op <= alu_pkg::SUB;
                            end else begin
                                state   <= DONE;
                                done    <= 1'b1;
                                alu_req <= 1'b0;
                                alu_op  <= alu_pkg::PASS;
                            end
`else
                            state   <= DONE;
                            done    <= 1'b1;
                            alu_req <= 1'b0;
                            alu_op  <= alu_pkg::PASS;
`endif
                        end
                    end
                end
`ifdef MUL_SIGNED_EN
                CORR_A: begin
                    if (alu_gnt) begin
                        hi <= alu_out;
                        if (sgn && orig_b[31]) begin
                            state <= CORR_B;
                        end else begin
                            state   <= DONE;
                            done    <= 1'b1;
                            alu_req <= 1'b0;
                            alu_op  <= alu_pkg::PASS;
                        end
                    end
                end
                CORR_B: begin
                    if (alu_gnt) begin
                        hi      <= alu_out;
                        state   <= DONE;
                        done    <= 1'b1;
                        alu_req <= 1'b0;
                        alu_op  <= alu_pkg::PASS;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    alu_req <= 1'b0;
                    alu_op  <= alu_pkg::PASS;
                end
            endcase
        end
    end

    // Operand muxes are zero whenever the ALU is not being borrowed.
    always_comb begin
        alu_a = '0;
        alu_b = '0;
        case (state)
            ITER: begin
                alu_a = hi;
                alu_b = lo[0] ? mcand : 32'd0;
            end
`ifdef MUL_SIGNED_EN
            CORR_A: begin
                alu_a = hi;
                alu_b = orig_b;
            end
            CORR_B: begin
                alu_a = hi;
                alu_b = mcand;
            end
`endif
            default: begin
                alu_a = '0;
                alu_b = '0;
            end
        endcase
    end

    assign alu_oe       = alu_req & alu_gnt;
    assign alu_carry_in = 1'b0;
    assign product_hi   = hi;
    assign product_lo   = lo;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
`ifdef MUL_SIGNED_EN
    logic        signed_in = 1'b0;
`endif
    logic        busy, done;
    logic [31:0] product_lo, product_hi;
    logic        alu_req, alu_oe, alu_carry_in;
    logic        alu_gnt = 1'b1;
    alu_op_e     alu_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_status;

    int checks = 0;
    int failures = 0;
    int sub_seen = 0;
    int bad_op = 0;
    int oe_bad = 0;
    int lat;

    alu_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
`ifdef MUL_SIGNED_EN
        .signed_in(signed_in),
`endif
        .busy(busy), .done(done),
        .product_lo(product_lo), .product_hi(product_hi),
        .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_oe(alu_oe),
        .alu_op(alu_op), .alu_carry_in(alu_carry_in),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_status(alu_status)
    );

    always #5 clk = ~clk;

    // Combinational model of the shared ALU.
    logic [32:0] r;
    logic        c;
    always_comb begin
        r = '0;
        c = 1'b0;
        case (alu_op)
            ADD: begin
                r = {1'b0, alu_a} + {1'b0, alu_b} + {32'd0, alu_carry_in};
                c = r[32];
            end
            SUB: begin
                r = {1'b0, alu_a} - {1'b0, alu_b};
                c = ~r[32];
            end
            default: begin
                r = {1'b0, alu_a};
                c = 1'b0;
            end
        endcase
        alu_out    = r[31:0];
        alu_status = {r[31], (r[31:0] == 32'd0), c, 1'b0};
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (alu_op == SUB) sub_seen++;
            if (alu_op != PASS && alu_op != ADD && alu_op != SUB) bad_op++;
            if (!alu_req && alu_op != PASS) bad_op++;
            if (alu_oe !== (alu_req & alu_gnt)) oe_bad++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a multiply and counts cycles to done (start cycle = 0).
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input int stall_at, input int stall_len,
                           input int poke_at, output int latency);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        alu_gnt      = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        multiplicand = 32'hDEAD0000;
        multiplier   = 32'h0000BEEF;
        latency      = 999;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                latency = n + 1;
                break;
            end
            if (n == 1) chk("busy_rise", {63'd0, busy}, 64'd1);
            if (n == stall_at) alu_gnt = 1'b0;
            if (n == stall_at + 1) begin
                chk("stall_oe", {63'd0, alu_oe}, 64'd0);
                chk("stall_req", {63'd0, alu_req}, 64'd1);
            end
            if (n == stall_at + stall_len) alu_gnt = 1'b1;
            if (n == poke_at) begin
                start        = 1'b1;
                multiplicand = 32'd7;
                multiplier   = 32'd7;
            end
            if (n == poke_at + 1) start = 1'b0;
        end
        alu_gnt = 1'b1;
        @(posedge clk);
        #1;
        chk("done_pulse", {63'd0, done}, 64'd0);
        chk("busy_fall", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_req_oe", {62'd0, alu_req, alu_oe}, 64'd0);
        chk("rst_op", {60'd0, alu_op}, {60'd0, PASS});
        chk("rst_ab", {alu_a, alu_b}, 64'd0);
        chk("rst_prod", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef MUL_SIGNED_EN
        signed_in = 1'b0;
`endif
        // 3 x 5
        run_mul(32'd3, 32'd5, -1, 0, -1, lat);
        chk("u3x5_lat", 64'(lat), 64'd33);
        chk("u3x5_prod", {product_hi, product_lo}, 64'd15);
        repeat (3) @(posedge clk);
        #1;
        chk("u3x5_hold", {product_hi, product_lo}, 64'd15);

        // all-ones squared: carry out on every iteration
        run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, -1, 0, -1, lat);
        chk("ones_lat", 64'(lat), 64'd33);
        chk("ones_prod", {product_hi, product_lo}, 64'hFFFFFFFE_00000001);

        // 2^31 squared = 2^62
        run_mul(32'h80000000, 32'h80000000, -1, 0, -1, lat);
        chk("msb_prod", {product_hi, product_lo}, 64'h40000000_00000000);

        // anything times zero
        run_mul(32'hDEADBEEF, 32'd0, -1, 0, -1, lat);
        chk("zero_prod", {product_hi, product_lo}, 64'd0);

        // grant withheld for 10 cycles after iteration 7
        run_mul(32'd3, 32'd5, 7, 10, -1, lat);
        chk("stall_lat", 64'(lat), 64'd43);
        chk("stall_prod", {product_hi, product_lo}, 64'd15);

        // start pulsed mid-operation with 7 x 7 is ignored
        run_mul(32'd3, 32'd5, -1, 0, 9, lat);
        chk("poke_lat", 64'(lat), 64'd33);
        chk("poke_prod", {product_hi, product_lo}, 64'd15);
        repeat (2) @(posedge clk);
        #1;
        chk("poke_idle", {63'd0, busy}, 64'd0);

        // reset mid-operation
        @(negedge clk);
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy_done", {62'd0, busy, done}, 64'd0);
        chk("abort_req_oe", {62'd0, alu_req, alu_oe}, 64'd0);
        chk("abort_op", {60'd0, alu_op}, {60'd0, PASS});
        chk("abort_ab", {alu_a, alu_b}, 64'd0);
        chk("abort_prod", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_mul(32'd2, 32'd2, -1, 0, -1, lat);
        chk("after_rst_lat", 64'(lat), 64'd33);
        chk("after_rst_prod", {product_hi, product_lo}, 64'd4);

`ifdef MUL_SIGNED_EN
        signed_in = 1'b1;
        run_mul(32'hFFFFFFFD, 32'd5, -1, 0, -1, lat);
        chk("s_neg_lat", 64'(lat), 64'd34);
        chk("s_neg_prod", {product_hi, product_lo}, 64'hFFFFFFFF_FFFFFFF1);
        // -3 x -5 = 15, both corrections
        run_mul(32'hFFFFFFFD, 32'hFFFFFFFB, -1, 0, -1, lat);
        chk("s_both_lat", 64'(lat), 64'd35);
        chk("s_both_prod", {product_hi, product_lo}, 64'd15);
        signed_in = 1'b0;
        run_mul(32'hFFFFFFFD, 32'd5, -1, 0, -1, lat);
        chk("u_neg_lat", 64'(lat), 64'd33);
        chk("u_neg_prod", {product_hi, product_lo}, 64'h00000004_FFFFFFF1);
`else
        chk("no_sub_issued", 64'(sub_seen), 64'd0);
`endif
        chk("op_legal", 64'(bad_op), 64'd0);
        chk("oe_equals_req_gnt", 64'(oe_bad), 64'd0);
        chk("carry_in_zero", {63'd0, alu_carry_in}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
